// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings, FSM states and the XLEN register-bus macro for the branch resolve unit.
`ifndef REG_BUS
`define REG_BUS logic [XLEN-1:0]
`endif

package branch_resolve_unit_pkg;

    localparam int unsigned BRU_OP_W = 3;

    typedef enum logic [BRU_OP_W-1:0] {
        BRU_OP_BEQ  = 3'd0,
        BRU_OP_BNE  = 3'd1,
        BRU_OP_BLT  = 3'd2,
        BRU_OP_BGE  = 3'd3,
        BRU_OP_BLTU = 3'd4,
        BRU_OP_BGEU = 3'd5,
        BRU_OP_JAL  = 3'd6,
        BRU_OP_JALR = 3'd7
    } bru_op_e;

    typedef enum logic {
        BRU_IDLE = 1'b0,
        BRU_HOLD = 1'b1
    } bru_state_e;

    // Unconditional control transfers that also write a link register.
    function automatic logic bru_is_jump(input logic [BRU_OP_W-1:0] op);
        return (op == BRU_OP_JAL) || (op == BRU_OP_JALR);
    endfunction

    function automatic logic bru_is_unsigned(input logic [BRU_OP_W-1:0] op);
        return (op == BRU_OP_BLTU) || (op == BRU_OP_BGEU);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Issue-side and result-side handshake bundle of the branch resolve unit.
interface branch_resolve_unit_if
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN = 64
);
    logic                in_valid;
    logic                in_ready;
    logic                in_epoch;
    logic [BRU_OP_W-1:0] in_op;
    `REG_BUS             in_pc, in_imm, in_rs1, in_rs2;
    logic                in_pred_taken;
    `REG_BUS             in_pred_target;

    logic                out_valid;
    logic                out_ready;
    `REG_BUS             out_link;
    logic                out_misalign;
    logic                redirect_valid;
    `REG_BUS             redirect_pc;
    logic                cur_epoch;

    modport master (
        output in_valid, in_epoch, in_op, in_pc, in_imm, in_rs1, in_rs2,
               in_pred_taken, in_pred_target, out_ready,
        input  in_ready, out_valid, out_link, out_misalign,
               redirect_valid, redirect_pc, cur_epoch
    );

    modport slave (
        input  in_valid, in_epoch, in_op, in_pc, in_imm, in_rs1, in_rs2,
               in_pred_taken, in_pred_target, out_ready,
        output in_ready, out_valid, out_link, out_misalign,
               redirect_valid, redirect_pc, cur_epoch
    );
endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition: signed/unsigned less-than, equality and taken decision.
module branch_cond
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [BRU_OP_W-1:0] op,
    input  logic [XLEN-1:0]     rs1,
    input  logic [XLEN-1:0]     rs2,
    output logic                taken,
    output logic                lt,
    output logic                eq
);

    assign eq = (rs1 == rs2);
    assign lt = bru_is_unsigned(op) ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));

    always_comb begin
        taken = 1'b0;
        case (op)
            BRU_OP_BEQ:  taken = eq;
            BRU_OP_BNE:  taken = !eq;
            BRU_OP_BLT:  taken = lt;
            BRU_OP_BGE:  taken = !lt;
            BRU_OP_BLTU: taken = lt;
            BRU_OP_BGEU: taken = !lt;
            BRU_OP_JAL:  taken = 1'b1;
            BRU_OP_JALR: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution with registered result, mispredict redirect and epoch tracking.
// Optional BRU_PERF_CNT_EN adds 64-bit branch and mispredict counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    branch_resolve_unit_if.slave   bus
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [63:0]            perf_branches,
    output logic [63:0]            perf_mispredicts
`endif
);

    bru_state_e      state_q;
    logic            epoch_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic [XLEN-1:0] link_q;
    logic            misalign_q;

    logic            taken_c, lt_c, eq_c;
    logic            is_jalr_c, is_jump_c;
    logic [XLEN-1:0] base_c, raw_target_c, target_c, seq_pc_c, next_pc_c;
    logic            mispredict_c, misalign_c;
    logic            in_ready_c, fire_c, fresh_c;
    logic            unused_cond;

    branch_cond #(.XLEN(XLEN)) u_cond (
        .op    (bus.in_op),
        .rs1   (bus.in_rs1),
        .rs2   (bus.in_rs2),
        .taken (taken_c),
        .lt    (lt_c),
        .eq    (eq_c)
    );

    assign unused_cond = lt_c ^ eq_c;

    // Target: JALR is register-relative with bit 0 forced low, everything else PC-relative.
    assign is_jalr_c    = (bus.in_op == BRU_OP_JALR);
    assign is_jump_c    = bru_is_jump(bus.in_op);
    assign base_c       = is_jalr_c ? bus.in_rs1 : bus.in_pc;
    assign raw_target_c = base_c + bus.in_imm;
    assign target_c     = is_jalr_c ? {raw_target_c[XLEN-1:1], 1'b0} : raw_target_c;
    assign seq_pc_c     = bus.in_pc + XLEN'(4);
    assign next_pc_c    = taken_c ? target_c : seq_pc_c;

    assign mispredict_c = (bus.in_pred_taken != taken_c) ||
                          (taken_c && (bus.in_pred_target != target_c));
    assign misalign_c   = (ALIGN_CHECK != 0) && taken_c && target_c[1];

    // Stale-epoch transfers are consumed but otherwise ignored.
    assign in_ready_c = (state_q == BRU_IDLE) || bus.out_ready;
    assign fire_c     = bus.in_valid && in_ready_c;
    assign fresh_c    = fire_c && (bus.in_epoch == epoch_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= BRU_IDLE;
            epoch_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            link_q           <= '0;
            misalign_q       <= 1'b0;
        end else begin
            redirect_valid_q <= fresh_c && mispredict_c;
            if (in_ready_c) begin
                state_q <= fresh_c ? BRU_HOLD : BRU_IDLE;
            end
            if (fresh_c) begin
                link_q     <= is_jump_c ? seq_pc_c : '0;
                misalign_q <= misalign_c;
            end
            if (fresh_c && mispredict_c) begin
                redirect_pc_q <= next_pc_c;
                epoch_q       <= ~epoch_q;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic [63:0] perf_branches_q, perf_mispredicts_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            if (fresh_c) begin
                perf_branches_q <= perf_branches_q + 64'd1;
            end
            if (fresh_c && mispredict_c) begin
                perf_mispredicts_q <= perf_mispredicts_q + 64'd1;
            end
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;
`endif

    assign bus.in_ready       = in_ready_c;
    assign bus.out_valid      = (state_q == BRU_HOLD);
    assign bus.out_link       = link_q;
    assign bus.out_misalign   = misalign_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.cur_epoch      = epoch_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed cases plus randomized traffic against a reference model.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    localparam int unsigned XLEN = 64;

    typedef struct {
        logic [63:0] link;
        logic        misalign;
        int          due;
    } out_exp_t;

    typedef struct {
        logic [63:0] pc;
        int          due;
    } rd_exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    branch_resolve_unit_if #(.XLEN(XLEN)) bus ();

`ifdef BRU_PERF_CNT_EN
    logic [63:0] perf_branches, perf_mispredicts;
`endif

    branch_resolve_unit #(.XLEN(XLEN), .ALIGN_CHECK(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
`ifdef BRU_PERF_CNT_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    out_exp_t    oq[$];
    rd_exp_t     rq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          m_epoch = 1'b0;
    bit          mon_epoch = 1'b0;
    bit          in_rst = 1'b1;
    logic [63:0] m_branches = '0;
    logic [63:0] m_mis = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Architectural meaning of each op, written straight from the ISA rules.
    task automatic ref_model(input logic [2:0] op, input logic [63:0] pc, input logic [63:0] imm,
                             input logic [63:0] rs1, input logic [63:0] rs2,
                             input bit pt, input logic [63:0] ptgt,
                             output bit tk, output logic [63:0] npc, output logic [63:0] link,
                             output bit mis, output bit mal);
        logic [63:0] tgt;
        longint      s1, s2;
        s1 = longint'(rs1);
        s2 = longint'(rs2);
        case (op)
            3'd0:    tk = (rs1 == rs2);
            3'd1:    tk = (rs1 != rs2);
            3'd2:    tk = (s1 < s2);
            3'd3:    tk = (s1 >= s2);
            3'd4:    tk = (rs1 < rs2);
            3'd5:    tk = (rs1 >= rs2);
            default: tk = 1'b1;
        endcase
        if (op == 3'd7) tgt = (rs1 + imm) & ~64'd1;
        else            tgt = pc + imm;
        link = (op >= 3'd6) ? pc + 64'd4 : 64'd0;
        npc  = tk ? tgt : pc + 64'd4;
        mis  = (pt != tk) || (tk && (ptgt != tgt));
        mal  = tk && tgt[1];
    endtask

    // Drive one cycle of stimulus and record what the DUT owes in response.
    task automatic send(input bit valid, input logic [2:0] op, input logic [63:0] pc,
                        input logic [63:0] imm, input logic [63:0] rs1, input logic [63:0] rs2,
                        input bit pt, input logic [63:0] ptgt, input bit epoch, input bit ordy);
        bit          exp_valid, rdy, tk, mis, mal;
        logic [63:0] npc, link;
        out_exp_t    oe;
        rd_exp_t     re;
        bus.in_valid       = valid;
        bus.in_op          = op;
        bus.in_pc          = pc;
        bus.in_imm         = imm;
        bus.in_rs1         = rs1;
        bus.in_rs2         = rs2;
        bus.in_pred_taken  = pt;
        bus.in_pred_target = ptgt;
        bus.in_epoch       = epoch;
        bus.out_ready      = ordy;
        exp_valid = (oq.size() > 0) && (oq[0].due <= cyc);
        rdy       = !exp_valid || ordy;
        if (valid && rdy && (epoch == m_epoch)) begin
            ref_model(op, pc, imm, rs1, rs2, pt, ptgt, tk, npc, link, mis, mal);
            oe.link = link; oe.misalign = mal; oe.due = cyc + 1;
            oq.push_back(oe);
            m_branches++;
            if (mis) begin
                re.pc = npc; re.due = cyc + 1;
                rq.push_back(re);
                m_epoch = ~m_epoch;
                m_mis++;
            end
        end
        @(posedge clock); #1;
        cyc++;
    endtask

    task automatic idle(input bit ordy);
        send(1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, m_epoch, ordy);
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clock); #1;
        cyc++;
        reset = 1'b0;
        oq.delete();
        rq.delete();
        m_epoch = 1'b0;
        mon_epoch = 1'b0;
        m_branches = '0;
        m_mis = '0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
        check("rst_redirect_pc", bus.redirect_pc, 64'd0);
        check("rst_out_link", bus.out_link, 64'd0);
        check("rst_out_misalign", 64'(bus.out_misalign), 64'd0);
        check("rst_cur_epoch", 64'(bus.cur_epoch), 64'd0);
`ifdef BRU_PERF_CNT_EN
        check("rst_perf_branches", perf_branches, 64'd0);
        check("rst_perf_mispredicts", perf_mispredicts, 64'd0);
`endif
        in_rst = 1'b0;
    endtask

    // Monitor: compares the presented result and redirect against the scoreboard queues.
    always @(negedge clock) begin : monitor
        bit ev;
        if (!in_rst) begin
            ev = (oq.size() > 0) && (oq[0].due <= cyc);
            check("out_valid", 64'(bus.out_valid), 64'(ev));
            check("in_ready", 64'(bus.in_ready), 64'(!ev || bus.out_ready));
            if (ev && bus.out_valid) begin
                check("out_link", bus.out_link, oq[0].link);
                check("out_misalign", 64'(bus.out_misalign), 64'(oq[0].misalign));
            end
            if (ev && bus.out_ready) void'(oq.pop_front());
            if ((rq.size() > 0) && (rq[0].due == cyc)) begin
                check("redirect_valid", 64'(bus.redirect_valid), 64'd1);
                check("redirect_pc", bus.redirect_pc, rq[0].pc);
                void'(rq.pop_front());
                mon_epoch = ~mon_epoch;
            end else begin
                check("redirect_idle", 64'(bus.redirect_valid), 64'd0);
            end
            check("cur_epoch", 64'(bus.cur_epoch), 64'(mon_epoch));
        end
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            default: return rnd64();
        endcase
    endfunction

    initial begin
        logic [63:0] pc, imm, rs1, rs2, ptgt, npc, link, r;
        logic [2:0]  op;
        bit          tk, mis, mal, pt, ep;

        do_reset();

        // Signed less-than taken, predicted not-taken: redirect to pc+imm and epoch flip.
        send(1'b1, BRU_OP_BLT, 64'h8000_0000, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
             1'b0, 64'd0, 1'b0, 1'b1);
        // Immediately following old-epoch instruction is consumed and dropped.
        send(1'b1, BRU_OP_BLTU, 64'h8000_0004, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
             1'b0, 64'd0, 1'b0, 1'b1);
        idle(1'b1);
        // Unsigned compare on the same operands is not taken: correct prediction.
        send(1'b1, BRU_OP_BLTU, 64'h8000_0010, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
             1'b0, 64'd0, m_epoch, 1'b1);
        // JALR clears bit 0 of the target; bit 1 set flags misalignment.
        send(1'b1, BRU_OP_JALR, 64'h8000_0014, 64'd0, 64'h8000_0103, 64'd0,
             1'b1, 64'h8000_0102, m_epoch, 1'b1);
        idle(1'b1);

        // Backpressure: result held for three cycles while a new input waits.
        send(1'b1, BRU_OP_JAL, 64'h1000, 64'h40, 64'd0, 64'd0, 1'b1, 64'h1040, m_epoch, 1'b1);
        for (int i = 0; i < 3; i++)
            send(1'b1, BRU_OP_BEQ, 64'h2000, 64'h8, 64'd5, 64'd5, 1'b1, 64'h2008, m_epoch, 1'b0);
        send(1'b1, BRU_OP_BEQ, 64'h2000, 64'h8, 64'd5, 64'd5, 1'b1, 64'h2008, m_epoch, 1'b1);
        idle(1'b1);

        // Reset while holding a mispredicted result.
        send(1'b1, BRU_OP_BNE, 64'h3000, 64'h20, 64'd1, 64'd2, 1'b0, 64'd0, m_epoch, 1'b0);
        do_reset();

        // Randomized traffic with backpressure, stale epochs and boundary operands.
        for (int n = 0; n < 3000; n++) begin
            op  = 3'($urandom_range(0, 7));
            pc  = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : (rnd64() & ~64'h3);
            r   = 64'($urandom_range(0, 4095));
            imm = ($urandom_range(0, 7) == 0) ? rnd64() : {{52{r[11]}}, r[11:0]};
            rs1 = pick_operand();
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : pick_operand();
            ref_model(op, pc, imm, rs1, rs2, 1'b0, 64'd0, tk, npc, link, mis, mal);
            pt   = ($urandom_range(0, 3) == 0) ? !tk : tk;
            ptgt = ($urandom_range(0, 3) == 0) ? rnd64() : npc;
            ep   = ($urandom_range(0, 9) == 0) ? !m_epoch : m_epoch;
            send($urandom_range(0, 3) != 0, op, pc, imm, rs1, rs2, pt, ptgt, ep,
                 $urandom_range(0, 9) < 7);
        end

        for (int i = 0; i < 4; i++) idle(1'b1);
        check("drain_results", 64'(oq.size()), 64'd0);
        check("drain_redirects", 64'(rq.size()), 64'd0);
`ifdef BRU_PERF_CNT_EN
        check("perf_branches", perf_branches, m_branches);
        check("perf_mispredicts", perf_mispredicts, m_mis);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
